aes_core_arbiter: RTL

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

---
 rtl/aes_core_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// aes_core_arbiter : round-robin front end sharing one AES core between two
//   requesters. Optional hung-core watchdog: define AES_CORE_ARBITER_TIMEOUT_EN
//   Rev 1.0
// ============================================================================
module aes_core_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clock,
   input  logic         resetModule_n,
   input  logic         req0_valid,
   input  logic         req1_valid,
   input  logic [127:0] req0_data,
   input  logic [127:0] req1_data,
   input  logic [127:0] req0_key,
   input  logic [127:0] req1_key,
   output logic         req0_ready,
   output logic         req1_ready,
   output logic         resp0_valid,
   output logic         resp1_valid,
   output logic [127:0] resp_data,
   output logic [127:0] core_inputData,
   output logic [127:0] core_key,
   output logic         core_inputsLoadedFlag,
   output logic         core_resetModule,
   input  logic [127:0] core_outputData,
   input  logic         core_doneFlag,
   output logic         err_timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
      $error("aes_core_arbiter: TIMEOUT_CYCLES must be within 1..65535");
   end

`ifdef AES_CORE_ARBITER_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ARB        = 3'd1,
      S_FLUSH      = 3'd2,
      S_FLUSH_WAIT = 3'd3,
      S_LAUNCH     = 3'd4,
      S_BUSY       = 3'd5,
      S_RESP       = 3'd6,
      S_TIMEOUT    = 3'd7
   } state_t;

   localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_busy_cnt;
`else
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ARB        = 3'd1,
      S_FLUSH      = 3'd2,
      S_FLUSH_WAIT = 3'd3,
      S_LAUNCH     = 3'd4,
      S_BUSY       = 3'd5,
      S_RESP       = 3'd6
   } state_t;

   assign err_timeout = 1'b0;
`endif

   state_t       r_state;
   logic         r_grant;
   logic         r_last_grant;
   logic         r_key_valid;
   logic [127:0] r_last_key;
   logic         r_wait_cnt;

   logic         w_any;
   logic         w_pick;
   logic         w_key_hit;

   // Contention goes to whoever was not served last; a lone request wins outright.
   assign w_any     = req0_valid | req1_valid;
   assign w_pick    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
   assign w_key_hit = r_key_valid && (core_key == r_last_key);

   always_ff @(posedge clock or negedge resetModule_n) begin
      if (!resetModule_n) begin
         r_state               <= S_IDLE;
         r_grant               <= 1'b0;
         r_last_grant          <= 1'b1;
         r_key_valid           <= 1'b0;
         r_last_key            <= '0;
         r_wait_cnt            <= 1'b0;
         req0_ready            <= 1'b0;
         req1_ready            <= 1'b0;
         resp0_valid           <= 1'b0;
         resp1_valid           <= 1'b0;
         resp_data             <= '0;
         core_inputData        <= '0;
         core_key              <= '0;
         core_inputsLoadedFlag <= 1'b0;
         core_resetModule      <= 1'b0;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
         r_busy_cnt            <= '0;
         err_timeout           <= 1'b0;
`endif
      end else begin
         req0_ready            <= 1'b0;
         req1_ready            <= 1'b0;
         resp0_valid           <= 1'b0;
         resp1_valid           <= 1'b0;
         core_inputsLoadedFlag <= 1'b0;
         core_resetModule      <= 1'b0;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
         err_timeout           <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant        <= w_pick;
                  core_inputData <= w_pick ? req1_data : req0_data;
                  core_key       <= w_pick ? req1_key  : req0_key;
                  req0_ready     <= ~w_pick;
                  req1_ready     <= w_pick;
                  r_state        <= S_ARB;
               end
            end
            S_ARB: begin
               if (w_key_hit) begin
                  core_inputsLoadedFlag <= 1'b1;
                  r_state               <= S_LAUNCH;
               end else begin
                  core_resetModule <= 1'b1;
                  r_state          <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               r_wait_cnt <= 1'b0;
               r_state    <= S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
               // Two settle cycles after the key flush before the new key is trusted.
               if (r_wait_cnt) begin
                  r_last_key            <= core_key;
                  r_key_valid           <= 1'b1;
                  core_inputsLoadedFlag <= 1'b1;
                  r_state               <= S_LAUNCH;
               end else begin
                  r_wait_cnt <= 1'b1;
               end
            end
            S_LAUNCH: begin
               r_state <= S_BUSY;
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
               r_busy_cnt <= '0;
`endif
            end
            S_BUSY: begin
               if (core_doneFlag) begin
                  resp_data   <= core_outputData;
                  resp0_valid <= ~r_grant;
                  resp1_valid <= r_grant;
                  r_state     <= S_RESP;
               end
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
               else if (r_busy_cnt == c_timeout_last) begin
                  // Hung core: flush it, forget the key and answer with zeros.
                  err_timeout      <= 1'b1;
                  core_resetModule <= 1'b1;
                  r_key_valid      <= 1'b0;
                  resp_data        <= '0;
                  resp0_valid      <= ~r_grant;
                  resp1_valid      <= r_grant;
                  r_state          <= S_TIMEOUT;
               end else begin
                  r_busy_cnt <= r_busy_cnt + 16'd1;
               end
`endif
            end
            S_RESP: begin
               r_last_grant <= r_grant;
               r_state      <= S_IDLE;
            end
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
            S_TIMEOUT: begin
               r_last_grant <= r_grant;
               r_state      <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
